rv32_mem_arbiter: RTL and testbench

Two-master to one-slave memory bus arbiter for the rv32 core. It shares the single system memory port between the fetch stage (instruction reads) and the memory stage (data loads and stores). It uses round-robin arbitration and captures each transaction at grant, so the bus is driven from registers. A timeout returns a fault so that fetch and memory can raise access-fault exceptions.

---
 rtl/rv32_bus_pkg.sv | 19 +
 rtl/rv32_bus_timeout.sv | 37 +++
 rtl/rv32_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_rv32_mem_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_bus_pkg.sv
// Shared types and widths for the rv32 memory bus arbiter.
package rv32_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_INSTR = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_t;

endpackage

// File: rtl/rv32_bus_timeout.sv
// Cycle counter that flags a granted transaction that has waited TIMEOUT cycles.
module rv32_bus_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] count_q, count_d;

  // Counting stops once expired so the counter can never wrap.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired && (TIMEOUT != 0)) begin
      count_d = count_q + 1'b1;
    end
  end

  assign expired = (TIMEOUT != 0) && enable && (count_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Round-robin arbiter sharing one registered memory port between fetch and data.
module rv32_mem_arbiter
  import rv32_bus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] instr_address_in,
  input  logic              instr_read_in,
  output logic [DATA_W-1:0] instr_read_value_out,
  output logic              instr_ready_out,
  output logic              instr_fault_out,
  input  logic [ADDR_W-1:0] data_address_in,
  input  logic              data_read_in,
  input  logic              data_write_in,
  input  logic [MASK_W-1:0] data_write_mask_in,
  input  logic [DATA_W-1:0] data_write_value_in,
  output logic [DATA_W-1:0] data_read_value_out,
  output logic              data_ready_out,
  output logic              data_fault_out,
  output logic [ADDR_W-1:0] mem_address_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic [MASK_W-1:0] mem_write_mask_out,
  output logic [DATA_W-1:0] mem_write_value_out,
  input  logic [DATA_W-1:0] mem_read_value_in,
  input  logic              mem_ready_in,
  output logic [1:0]        owner_out
);

  arb_state_t        state_q, state_d;
  owner_t            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] value_q, value_d;

  logic data_req;
  logic grant_instr;
  logic grant_data;
  logic active;
  logic expired;
  logic done;

  assign data_req = data_read_in | data_write_in;
  assign active   = (state_q != ARB_IDLE);
  assign done     = active && (mem_ready_in || expired);

  // On a tie the master that did not win last time gets the bus.
  always_comb begin
    grant_instr = 1'b0;
    grant_data  = 1'b0;
    if (state_q == ARB_IDLE) begin
      if (instr_read_in && data_req) begin
        grant_instr = (last_grant_q == OWNER_DATA);
        grant_data  = (last_grant_q == OWNER_INSTR);
      end else begin
        grant_instr = instr_read_in;
        grant_data  = data_req;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    mask_d       = mask_q;
    value_d      = value_q;
    if (grant_instr) begin
      state_d      = ARB_INSTR;
      last_grant_d = OWNER_INSTR;
      address_d    = instr_address_in;
      read_d       = 1'b1;
      write_d      = 1'b0;
      mask_d       = '0;
      value_d      = '0;
    end else if (grant_data) begin
      state_d      = ARB_DATA;
      last_grant_d = OWNER_DATA;
      address_d    = data_address_in;
      read_d       = data_read_in;
      write_d      = data_write_in;
      mask_d       = data_write_mask_in;
      value_d      = data_write_value_in;
    end else if (done) begin
      state_d = ARB_IDLE;
      read_d  = 1'b0;
      write_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= OWNER_DATA;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      mask_q       <= '0;
      value_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      mask_q       <= mask_d;
      value_q      <= value_d;
    end
  end

  // A same-cycle slave ready suppresses the timeout via the enable.
  rv32_bus_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (grant_instr | grant_data),
    .enable (active && !mem_ready_in),
    .expired(expired)
  );

  assign instr_ready_out      = done && (state_q == ARB_INSTR);
  assign instr_fault_out      = expired && (state_q == ARB_INSTR);
  assign instr_read_value_out = instr_fault_out ? '0 : mem_read_value_in;
  assign data_ready_out       = done && (state_q == ARB_DATA);
  assign data_fault_out       = expired && (state_q == ARB_DATA);
  assign data_read_value_out  = data_fault_out ? '0 : mem_read_value_in;

  assign mem_address_out     = address_q;
  assign mem_read_out        = read_q;
  assign mem_write_out       = write_q;
  assign mem_write_mask_out  = mask_q;
  assign mem_write_value_out = value_q;
  assign owner_out           = state_q;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Scoreboard bench: randomized fetch/data traffic against a transaction-level model of the arbiter.
module tb_rv32_mem_arbiter;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_address_in = '0;
  logic        instr_read_in = 1'b0;
  logic [31:0] instr_read_value_out;
  logic        instr_ready_out;
  logic        instr_fault_out;
  logic [31:0] data_address_in = '0;
  logic        data_read_in = 1'b0;
  logic        data_write_in = 1'b0;
  logic [3:0]  data_write_mask_in = '0;
  logic [31:0] data_write_value_in = '0;
  logic [31:0] data_read_value_out;
  logic        data_ready_out;
  logic        data_fault_out;
  logic [31:0] mem_address_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic [3:0]  mem_write_mask_out;
  logic [31:0] mem_write_value_out;
  logic [31:0] mem_read_value_in = '0;
  logic        mem_ready_in = 1'b0;
  logic [1:0]  owner_out;

  always #5 clk = ~clk;

  rv32_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk                 (clk),
    .reset               (reset),
    .instr_address_in    (instr_address_in),
    .instr_read_in       (instr_read_in),
    .instr_read_value_out(instr_read_value_out),
    .instr_ready_out     (instr_ready_out),
    .instr_fault_out     (instr_fault_out),
    .data_address_in     (data_address_in),
    .data_read_in        (data_read_in),
    .data_write_in       (data_write_in),
    .data_write_mask_in  (data_write_mask_in),
    .data_write_value_in (data_write_value_in),
    .data_read_value_out (data_read_value_out),
    .data_ready_out      (data_ready_out),
    .data_fault_out      (data_fault_out),
    .mem_address_out     (mem_address_out),
    .mem_read_out        (mem_read_out),
    .mem_write_out       (mem_write_out),
    .mem_write_mask_out  (mem_write_mask_out),
    .mem_write_value_out (mem_write_value_out),
    .mem_read_value_in   (mem_read_value_in),
    .mem_ready_in        (mem_ready_in),
    .owner_out           (owner_out)
  );

  typedef struct {
    bit          is_instr;
    logic [31:0] addr;
    bit          rd;
    bit          wr;
    logic [3:0]  mask;
    logic [31:0] wval;
    int          lat;
    logic [31:0] rdata;
  } txn_t;

  txn_t        exp_q[$];
  int          lat_q[$];
  logic [31:0] dat_q[$];
  int          err_cnt = 0;
  int          chk_cnt = 0;
  bit          last_data = 1'b1;
  bit          force_ready = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name, input string what);
    chk_cnt++;
    err_cnt++;
    $display("[TB] FAIL %s: %s", name, what);
  endtask

  // Slave: answers each bus transaction after the latency the stimulus chose.
  bit          s_busy = 1'b0;
  int          s_cyc = 0;
  int          s_lat = 0;
  logic [31:0] s_data = '0;
  always begin
    @(posedge clk);
    #1;
    if (force_ready) begin
      s_busy = 1'b0;
      mem_ready_in = 1'b1;
      mem_read_value_in = $urandom;
    end else if (mem_read_out || mem_write_out) begin
      if (!s_busy) begin
        s_busy = 1'b1;
        s_cyc = 1;
        if (lat_q.size() > 0) begin
          s_lat = lat_q.pop_front();
          s_data = dat_q.pop_front();
        end else begin
          s_lat = 1000;
          s_data = '0;
        end
      end else begin
        s_cyc++;
      end
      if (s_cyc == s_lat) begin
        mem_ready_in = 1'b1;
        mem_read_value_in = s_data;
      end else begin
        mem_ready_in = 1'b0;
        mem_read_value_in = $urandom;
      end
    end else begin
      s_busy = 1'b0;
      mem_ready_in = 1'($urandom_range(0, 1));
      mem_read_value_in = $urandom;
    end
  end

  // Monitor: checks the bus against the head of the scoreboard and pops on each ready.
  bit   prev_active = 1'b0;
  bit   gap_due = 1'b0;
  int   mcyc = 0;
  bit   act;
  bit   efault;
  int   ecyc;
  txn_t e;
  always @(negedge clk) begin
    if (!reset) begin
      act = mem_read_out | mem_write_out;
      if (gap_due) begin
        checkOutput("gap_owner", 32'(owner_out), 32'd0);
        checkOutput("gap_bus", {30'd0, mem_read_out, mem_write_out}, 32'd0);
        gap_due = 1'b0;
      end
      mcyc = act ? (prev_active ? mcyc + 1 : 1) : 0;
      if (act) begin
        if (exp_q.size() == 0) begin
          failNow("bus_activity", "bus active with no granted transaction expected");
        end else begin
          e = exp_q[0];
          checkOutput("bus_addr", mem_address_out, e.addr);
          checkOutput("bus_rw", {30'd0, mem_read_out, mem_write_out}, {30'd0, e.rd, e.wr});
          checkOutput("bus_mask", 32'(mem_write_mask_out), 32'(e.mask));
          checkOutput("owner", 32'(owner_out), e.is_instr ? 32'd1 : 32'd2);
          if (!e.is_instr) checkOutput("bus_wval", mem_write_value_out, e.wval);
        end
      end
      if (instr_ready_out || data_ready_out) begin
        if (exp_q.size() == 0) begin
          failNow("spurious_ready", "ready pulse with no transaction pending");
        end else begin
          e = exp_q.pop_front();
          efault = (e.lat > TIMEOUT);
          ecyc = efault ? TIMEOUT : e.lat;
          checkOutput("ready_who", {30'd0, instr_ready_out, data_ready_out},
                      e.is_instr ? 32'd2 : 32'd1);
          checkOutput("fault", {30'd0, instr_fault_out, data_fault_out},
                      efault ? (e.is_instr ? 32'd2 : 32'd1) : 32'd0);
          checkOutput("ready_cycle", 32'(mcyc), 32'(ecyc));
          if (e.is_instr) begin
            checkOutput("rvalue", instr_read_value_out, efault ? 32'd0 : e.rdata);
            checkOutput("other_rvalue", data_read_value_out, mem_read_value_in);
          end else begin
            checkOutput("rvalue", data_read_value_out, efault ? 32'd0 : e.rdata);
            checkOutput("other_rvalue", instr_read_value_out, mem_read_value_in);
          end
          gap_due = 1'b1;
        end
      end
      prev_active = act;
    end else begin
      prev_active = 1'b0;
      gap_due = 1'b0;
      mcyc = 0;
    end
  end

  function automatic txn_t randInstr();
    txn_t t;
    t.is_instr = 1'b1;
    t.addr = $urandom & 32'hFFFF_FFFC;
    t.rd = 1'b1;
    t.wr = 1'b0;
    t.mask = '0;
    t.wval = '0;
    t.lat = int'($urandom_range(1, 6));
    t.rdata = $urandom;
    return t;
  endfunction

  function automatic txn_t randData();
    txn_t t;
    int op;
    op = int'($urandom_range(1, 3));
    t.is_instr = 1'b0;
    t.addr = $urandom;
    t.rd = (op != 2);
    t.wr = (op != 1);
    t.mask = 4'($urandom);
    t.wval = $urandom;
    t.lat = int'($urandom_range(1, 6));
    t.rdata = $urandom;
    return t;
  endfunction

  function automatic void pushExp(input txn_t t);
    exp_q.push_back(t);
    lat_q.push_back(t.lat);
    dat_q.push_back(t.rdata);
  endfunction

  // pattern: 0 fetch only, 1 data only, 2 both at once.
  task automatic applyStimulus(input int pattern, input txn_t ti, input txn_t td, input bit withdraw);
    bit win_instr;
    int budget;
    win_instr = (pattern == 0) || (pattern == 2 && last_data);
    if (pattern == 0) begin
      pushExp(ti);
      last_data = 1'b0;
    end else if (pattern == 1) begin
      pushExp(td);
      last_data = 1'b1;
    end else if (win_instr) begin
      pushExp(ti);
      pushExp(td);
      last_data = 1'b1;
    end else begin
      pushExp(td);
      pushExp(ti);
      last_data = 1'b0;
    end
    @(negedge clk);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    if (pattern != 1) begin
      instr_address_in = ti.addr;
      instr_read_in = 1'b1;
    end
    if (pattern != 0) begin
      data_address_in = td.addr;
      data_read_in = td.rd;
      data_write_in = td.wr;
      data_write_mask_in = td.mask;
      data_write_value_in = td.wval;
    end
    budget = 0;
    do begin
      @(negedge clk);
      if (budget == 0 && withdraw) begin
        if (win_instr) begin
          instr_read_in = 1'b0;
          instr_address_in = $urandom;
        end else begin
          data_read_in = 1'b0;
          data_write_in = 1'b0;
          data_address_in = '0;
          data_write_mask_in = '0;
          data_write_value_in = '0;
        end
      end
      if (instr_ready_out) instr_read_in = 1'b0;
      if (data_ready_out) begin
        data_read_in = 1'b0;
        data_write_in = 1'b0;
      end
      budget++;
    end while (exp_q.size() > 0 && budget < 60);
    if (exp_q.size() > 0) begin
      failNow("round_timeout", "transactions still pending after 60 cycles");
      exp_q.delete();
      lat_q.delete();
      dat_q.delete();
    end
    instr_read_in = 1'b0;
    data_read_in = 1'b0;
    data_write_in = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_owner"}, 32'(owner_out), 32'd0);
    checkOutput({tag, "_rw"}, {30'd0, mem_read_out, mem_write_out}, 32'd0);
    checkOutput({tag, "_addr"}, mem_address_out, 32'd0);
    checkOutput({tag, "_mask"}, 32'(mem_write_mask_out), 32'd0);
    checkOutput({tag, "_wval"}, mem_write_value_out, 32'd0);
    checkOutput({tag, "_ready"}, {28'd0, instr_ready_out, instr_fault_out, data_ready_out, data_fault_out}, 32'd0);
  endtask

  initial begin
    txn_t ti, td;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    reset = 1'b0;

    // Tie right after reset: fetch first, then strict alternation.
    for (int i = 0; i < 3; i++) begin
      ti = randInstr();
      td = randData();
      ti.lat = 1;
      td.lat = 1;
      applyStimulus(2, ti, td, 1'b0);
    end

    ti = randInstr();
    ti.addr = 32'h0000_0100;
    ti.lat = 2;
    ti.rdata = 32'hDEAD_BEEF;
    applyStimulus(0, ti, td, 1'b0);

    td = randData();
    td.addr = 32'h0000_2004;
    td.rd = 1'b0;
    td.wr = 1'b1;
    td.mask = 4'b0011;
    td.wval = 32'h1234_5678;
    td.lat = 3;
    applyStimulus(1, ti, td, 1'b1);

    td = randData();
    td.lat = 100;
    applyStimulus(1, ti, td, 1'b0);

    td = randData();
    td.lat = TIMEOUT;
    applyStimulus(1, ti, td, 1'b0);

    ti = randInstr();
    ti.lat = TIMEOUT + 2;
    applyStimulus(0, ti, td, 1'b0);

    for (int i = 0; i < 60; i++) begin
      applyStimulus(int'($urandom_range(0, 2)), randInstr(), randData(), ($urandom_range(0, 3) == 0));
    end

    // Reset during a pending fetch that the slave never answers.
    ti = randInstr();
    ti.lat = 1000;
    pushExp(ti);
    last_data = 1'b0;
    @(negedge clk);
    instr_address_in = ti.addr;
    instr_read_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    exp_q.delete();
    lat_q.delete();
    dat_q.delete();
    instr_read_in = 1'b0;
    @(negedge clk);
    checkIdleOutputs("midreset");
    reset = 1'b0;
    force_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("late_ready", {30'd0, instr_ready_out, data_ready_out}, 32'd0);
    end
    force_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
